// File: rtl/uart_word_receiver.sv
// ============================================================================
// uart_word_receiver : 8N1 UART receiver packing four bytes into a 32-bit word
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_word_receiver #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD;
  localparam int HALF_BIT       = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW             = $clog2(CLKS_PER_BIT);
  localparam int TOW            = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  HALF_LAST = TW'(HALF_BIT - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic           rx_meta_q, rx_sync_q;
  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [1:0]     idx_q, idx_d;
  logic [23:0]    partial_q, partial_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]    word_out_q, word_out_d;
  logic           word_valid_q, word_valid_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_q, overrun_d;
  logic           byte_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      partial_q    <= '0;
      to_cnt_q     <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      partial_q    <= partial_d;
      to_cnt_q     <= to_cnt_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    partial_d    = partial_q;
    to_cnt_d     = to_cnt_q;
    word_out_d   = word_out_q;
    word_valid_d = word_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    byte_accept  = 1'b0;

    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_sync_q) begin
          state_d = START;
        end
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_sync_q) begin
            byte_accept = 1'b1;
            state_d     = IDLE;
          end else begin
            frame_err_d = 1'b1;
            idx_d       = '0;
            state_d     = WAIT_HIGH;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_sync_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Lane 3 completes the word; a pending unconsumed word wins over the new one.
    if (byte_accept) begin
      idx_d = idx_q + 1'b1;
      case (idx_q)
        2'd0: partial_d[23:16] = shift_q;
        2'd1: partial_d[15:8]  = shift_q;
        2'd2: partial_d[7:0]   = shift_q;
        default: begin
          if (word_valid_q && !word_ready) begin
            overrun_d = 1'b1;
          end else begin
            word_out_d   = {partial_q, shift_q};
            word_valid_d = 1'b1;
          end
        end
      endcase
    end

    if (state_q != IDLE || idx_q == 2'd0 || !rx_sync_q) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LAST) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      idx_d = '0;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_receiver.sv
// ============================================================================
// tb_uart_word_receiver : directed self-checking bench for uart_word_receiver
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_word_receiver;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        word_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        frame_err;
  logic        overrun;

  int vectors     = 0;
  int miscompares = 0;

  int wv_cyc = 0, words = 0, fe_cnt = 0, ov_cnt = 0, pulse_viol = 0;
  logic wv_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;

  uart_word_receiver #(
    .CLK_FREQ    (16),
    .BAUD        (1),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe outputs on the falling edge, half a period away from updates.
  always @(negedge clk) begin
    if (word_valid) wv_cyc++;
    if (word_valid && !wv_prev) words++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if ((frame_err && fe_prev) || (overrun && ov_prev)) pulse_viol++;
    wv_prev = word_valid;
    fe_prev = frame_err;
    ov_prev = overrun;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [7:0] v;
    v  = b;
    rx = 1'b0;
    cycles(16);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      cycles(16);
    end
    rx = stop_bit;
    cycles(16);
    rx = 1'b1;
  endtask

  int s_wv, s_words, s_fe, s_ov;

  task automatic snap();
    s_wv    = wv_cyc;
    s_words = words;
    s_fe    = fe_cnt;
    s_ov    = ov_cnt;
  endtask

  initial begin
    rst_n      = 1'b0;
    rx         = 1'b1;
    word_ready = 1'b1;
    cycles(4);
    check("reset_word_out", word_out, 32'h0);
    check("reset_valid", {31'd0, word_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    cycles(4);

    // Basic word with consumer always ready
    snap();
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    cycles(4);
    check("deadbeef_word", word_out, 32'hDEADBEEF);
    check("deadbeef_valid_cycles", 32'(wv_cyc - s_wv), 32'd1);
    check("deadbeef_words", 32'(words - s_words), 32'd1);
    check("deadbeef_no_fe", 32'(fe_cnt - s_fe), 32'd0);
    check("deadbeef_no_ov", 32'(ov_cnt - s_ov), 32'd0);

    // Framing error then a clean word
    snap();
    send_byte(8'h55, 1'b0);
    cycles(4);
    check("fe_pulse", 32'(fe_cnt - s_fe), 32'd1);
    check("fe_no_word", 32'(words - s_words), 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    cycles(4);
    check("fe_next_word", word_out, 32'h01020304);
    check("fe_next_words", 32'(words - s_words), 32'd1);

    // Overrun: consumer stalled across two complete words
    word_ready = 1'b0;
    snap();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    cycles(4);
    check("ovr_first_word", word_out, 32'h11223344);
    check("ovr_first_valid", {31'd0, word_valid}, 32'd1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    cycles(4);
    check("ovr_word_kept", word_out, 32'h11223344);
    check("ovr_valid_kept", {31'd0, word_valid}, 32'd1);
    check("ovr_pulses", 32'(ov_cnt - s_ov), 32'd1);
    word_ready = 1'b1;
    cycles(1);
    check("ovr_consumed", {31'd0, word_valid}, 32'd0);
    check("ovr_word_stable", word_out, 32'h11223344);

    // Inter-byte timeout discards a partial word
    snap();
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    cycles(320);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h0B, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h0D, 1'b1);
    cycles(4);
    check("timeout_word", word_out, 32'h0A0B0C0D);
    check("timeout_words", 32'(words - s_words), 32'd1);

    // Short low glitch is rejected silently
    snap();
    rx = 1'b0;
    cycles(5);
    rx = 1'b1;
    cycles(40);
    check("glitch_word", word_out, 32'h0A0B0C0D);
    check("glitch_valid", {31'd0, word_valid}, 32'd0);
    check("glitch_events", 32'((words - s_words) + (fe_cnt - s_fe) + (ov_cnt - s_ov)), 32'd0);

    // Reset mid-word drops the partial bytes
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1);
    send_byte(8'hA3, 1'b1);
    rst_n = 1'b0;
    cycles(3);
    check("midrst_word_out", word_out, 32'h0);
    check("midrst_valid", {31'd0, word_valid}, 32'd0);
    rst_n = 1'b1;
    cycles(2);
    snap();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    cycles(4);
    check("midrst_new_word", word_out, 32'h12345678);
    check("midrst_words", 32'(words - s_words), 32'd1);
    check("pulse_width", 32'(pulse_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_word_receiver.md
UART_WORD_RECEIVER -- requirements
Module: uart_word_receiver

Interface
REQ-001: Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002: Parameter BAUD, default 115200, serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated, and SHALL be >= 4.
REQ-003: Parameter TIMEOUT_BITS, default 20, idle bit-times after which a partial word is discarded.
REQ-004: clk, input, 1, single system clock; all logic on its rising edge.
REQ-005: rst_n, input, 1, synchronous active-low reset.
REQ-006: rx, input, 1, asynchronous serial line, 8N1, idle high.
REQ-007: word_out, output, 32, last assembled word; first received byte in [31:24], fourth in [7:0].
REQ-008: word_valid, output, 1, high while word_out holds an unconsumed word.
REQ-009: word_ready, input, 1, consumer accepts word_out in any cycle where word_valid and word_ready are both high.
REQ-010: frame_err, output, 1, one-cycle pulse when a stop bit samples low.
REQ-011: overrun, output, 1, one-cycle pulse when a completed word is dropped.

Function
REQ-012: rx SHALL pass through a 2-flop synchronizer. All further rx references mean the synchronized value.
REQ-013: Bit FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014: IDLE: rx=0 -> START, and the bit-timer is cleared.
REQ-015: START: after CLKS_PER_BIT/2 cycles, rx=0 -> DATA; rx=1 -> IDLE (glitch rejected, no pulse).
REQ-016: DATA: sample rx every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register, then -> STOP.
REQ-017: STOP: after CLKS_PER_BIT cycles, sample rx. rx=1 -> byte accepted, -> IDLE.
REQ-018: STOP with rx=0 SHALL pulse frame_err, discard the byte, reset byte index to 0, and go to WAIT_HIGH.
REQ-019: WAIT_HIGH -> IDLE on the first cycle with rx=1.
REQ-020: Byte index (0..3) SHALL select the target lane. Index 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-021: Index SHALL increment per accepted byte and wrap 3 -> 0.
REQ-022: On the 4th accepted byte, the assembled word SHALL transfer to word_out and word_valid SHALL rise in the cycle after the stop-bit sample.
REQ-023: word_valid SHALL stay high and word_out stable until a handshake cycle; word_valid then clears the next cycle.
REQ-024: Word completes while word_valid=1 and word_ready=0: the new word is dropped, overrun pulses, and word_out/word_valid are unchanged.
REQ-025: Word completes while word_valid=1 and word_ready=1: the old word is consumed, the new word is loaded, word_valid stays 1, and there is no overrun.
REQ-026: Inter-byte timeout: with index != 0 and FSM in IDLE for TIMEOUT_BITS*CLKS_PER_BIT consecutive cycles, index SHALL reset to 0 and the partial bytes are discarded with no output pulse.
REQ-027: The timeout counter SHALL clear on any start-bit entry and saturate at its terminal value.
REQ-028: frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-029: rst_n=0 at a clock edge SHALL force FSM=IDLE, byte index=0, bit-timer=0, timeout counter=0, synchronizer flops=1, word_out=32'h0, word_valid=0, frame_err=0, overrun=0.
REQ-030: Reset mid-frame or mid-word SHALL discard all partial data. After release, the receiver SHALL wait for a fresh falling edge (rx high for at least 1 cycle is not required).
REQ-031: Outputs SHALL be registered and free of combinational paths from rx or word_ready.

Verification (CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16; TIMEOUT_BITS=20)
REQ-032: Send bytes DE,AD,BE,EF with word_ready=1. Required: word_out=32'hDEADBEEF, word_valid high exactly 1 cycle, no frame_err or overrun.
REQ-033: Send byte 0x55 with a low stop bit, then 4 bytes 01,02,03,04. Required: one frame_err pulse, then word_out=32'h01020304.
REQ-034: Hold word_ready=0 and send 2 words 11223344 and AABBCCDD. Required: word_out stays 32'h11223344, valid stays 1, one overrun pulse.
REQ-035: Send 2 bytes, idle 320 cycles, then send 4 bytes 0A,0B,0C,0D. Required: word_out=32'h0A0B0C0D, no spurious word.
REQ-036: Drive a 5-cycle low glitch on rx. Required: FSM returns to IDLE, no outputs change.
REQ-037: Assert rst_n=0 after 3 bytes, then send 4 bytes 12,34,56,78. Required: word_out=32'h12345678.
